// File: rtl/gan_ctrl_pkg.sv
// Shared constants for the GAN pipeline controller: parameter geometry,
// FSM state encoding and per-layer base indices into the parameter bank.
package gan_ctrl_pkg;

  localparam int NUM_PARAMS = 73;
  localparam int PARAM_W    = 6;
  localparam int CFG_ADDR_W = 7;

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // First parameter index of each datapath layer.
  localparam int L1_BASE = 0;
  localparam int L2_BASE = 20;
  localparam int L3_BASE = 30;
  localparam int L4_BASE = 33;
  localparam int L5_BASE = 35;
  localparam int L6_BASE = 37;
  localparam int L7_BASE = 41;
  localparam int L8_BASE = 53;

  function automatic int param_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/gan_valid_tracker.sv
// Valid-bit shift register mirroring the datapath pipeline, plus a running
// count of valid samples currently in flight.
module gan_valid_tracker #(
  parameter int PIPE_LAT = 24
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              shift_en,
  input  logic                              valid_in,
  output logic                              valid_out,
  output logic [$clog2(PIPE_LAT+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(PIPE_LAT + 1);

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  always_comb begin
    vld_d = vld_q;
    occ_d = occ_q;
    if (shift_en) begin
      vld_d = {vld_q[PIPE_LAT-2:0], valid_in};
      occ_d = occ_q + OCC_W'(valid_in) - OCC_W'(vld_q[PIPE_LAT-1]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign valid_out = vld_q[PIPE_LAT-1];
  assign occupancy = occ_q;

endmodule

// File: rtl/gan_pipeline_ctrl.sv
// Controller for the 8-layer GAN datapath: serial parameter bank, global
// enable gating with backpressure, and valid tracking. `GAN_CTRL_PERF_EN adds perf counters.
module gan_pipeline_ctrl #(
  parameter int PIPE_LAT   = 24,
  parameter int NUM_PARAMS = gan_ctrl_pkg::NUM_PARAMS,
  parameter int PARAM_W    = gan_ctrl_pkg::PARAM_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [6:0]                        cfg_addr,
  input  logic [PARAM_W-1:0]                cfg_data,
  input  logic                              cfg_commit,
  input  logic                              cfg_req,
  output logic                              cfg_err,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [23:0]                       in_x,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              dp_enable,
  output logic [23:0]                       dp_x,
  output logic [NUM_PARAMS*PARAM_W-1:0]     dp_params,
  output logic [$clog2(PIPE_LAT+1)-1:0]     occupancy,
  output logic [1:0]                        state
`ifdef GAN_CTRL_PERF_EN
  ,
  output logic [31:0]                       perf_samples,
  output logic [31:0]                       perf_stalls
`endif
);

  import gan_ctrl_pkg::*;

  localparam logic [6:0] ADDR_LIMIT = 7'(NUM_PARAMS);

  state_e state_q, state_d;
  logic   cfg_err_q, cfg_err_d;
  logic   stall;
  logic   accept;
  logic   cfg_we;
  logic   vld_out;

  // A stalled output freezes everything; there is no partial advance.
  assign stall = vld_out & ~out_ready;

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    dp_enable = 1'b0;
    case (state_q)
      CFG: begin
        cfg_ready = 1'b1;
        if (cfg_commit) state_d = RUN;
      end
      RUN: begin
        in_ready  = ~stall;
        dp_enable = ~stall;
        if (cfg_req) state_d = DRAIN;
      end
      DRAIN: begin
        dp_enable = ~stall;
        if (occupancy == '0) state_d = CFG;
      end
      default: state_d = CFG;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign cfg_we    = cfg_valid & cfg_ready;
  assign cfg_err_d = cfg_err_q | (cfg_we & (cfg_addr >= ADDR_LIMIT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CFG;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Writes only land in CFG, so parameters are frozen while samples flow.
  generate
    for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
      logic [PARAM_W-1:0] param_q, param_d;

      always_comb begin
        param_d = param_q;
        if (cfg_we && (cfg_addr == 7'(gi))) param_d = cfg_data;
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) param_q <= '0;
        else       param_q <= param_d;
      end

      assign dp_params[param_lsb(gi, PARAM_W) +: PARAM_W] = param_q;
    end
  endgenerate

  gan_valid_tracker #(
    .PIPE_LAT (PIPE_LAT)
  ) u_valid_tracker (
    .clock     (clock),
    .reset     (reset),
    .shift_en  (dp_enable),
    .valid_in  (accept),
    .valid_out (vld_out),
    .occupancy (occupancy)
  );

`ifdef GAN_CTRL_PERF_EN
  logic [31:0] perf_samples_q, perf_samples_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_samples_d = perf_samples_q;
    perf_stalls_d  = perf_stalls_q;
    if (vld_out && out_ready && !(&perf_samples_q)) perf_samples_d = perf_samples_q + 32'd1;
    if (stall && !(&perf_stalls_q))                 perf_stalls_d  = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_samples_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_samples_q <= perf_samples_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_samples = perf_samples_q;
  assign perf_stalls  = perf_stalls_q;
`endif

  assign cfg_err   = cfg_err_q;
  assign out_valid = vld_out;
  assign dp_x      = in_x;
  assign state     = state_q;

endmodule

// File: tb/tb_gan_pipeline_ctrl.sv
// Directed bench for gan_pipeline_ctrl: config writes, streaming latency,
// backpressure, drain and asynchronous reset, with a timing scoreboard.
module tb_gan_pipeline_ctrl;

  localparam int PIPE_LAT = 24;
  localparam int NP       = 73;
  localparam int PW       = 6;
  localparam int OCC_W    = $clog2(PIPE_LAT + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_valid, cfg_ready, cfg_commit, cfg_req, cfg_err;
  logic [6:0]        cfg_addr;
  logic [PW-1:0]     cfg_data;
  logic              in_valid, in_ready, out_valid, out_ready, dp_enable;
  logic [23:0]       in_x, dp_x;
  logic [NP*PW-1:0]  dp_params;
  logic [OCC_W-1:0]  occupancy;
  logic [1:0]        state;
`ifdef GAN_CTRL_PERF_EN
  logic [31:0]       perf_samples, perf_stalls;
`endif

  always #5 clock = ~clock;

  gan_pipeline_ctrl #(.PIPE_LAT(PIPE_LAT), .NUM_PARAMS(NP), .PARAM_W(PW)) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_req(cfg_req), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .dp_enable(dp_enable), .dp_x(dp_x), .dp_params(dp_params),
    .occupancy(occupancy), .state(state)
`ifdef GAN_CTRL_PERF_EN
    , .perf_samples(perf_samples), .perf_stalls(perf_stalls)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int extra_lat = 0;
  int sb_q[$];
  logic [NP*PW-1:0] exp_params;

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples handshakes at the end of the current cycle, then advances one clock.
  task automatic tick();
    int e;
    #1;
    if (!reset) begin
      if (in_valid && in_ready) sb_q.push_back(cyc + PIPE_LAT + extra_lat);
      if (out_valid && out_ready) begin
        hs_cnt++;
        chk("sb_nonempty", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_out_cycle", cyc, e);
          $display("output handshake at cycle %0d (expected %0d)", cyc, e);
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input logic [6:0] addr, input logic [PW-1:0] data, input logic commit);
    cfg_valid  = 1'b1;
    cfg_addr   = addr;
    cfg_data   = data;
    cfg_commit = commit;
    tick();
    $display("cfg write addr=%0d data=%0h commit=%0b", addr, data, commit);
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hs0, occ_max;
    cfg_valid = 0; cfg_commit = 0; cfg_req = 0; cfg_addr = '0; cfg_data = '0;
    in_valid = 0; in_x = '0; out_ready = 1;
    exp_params = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_dp_enable", dp_enable, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, '0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_params", dp_params, '0);
    reset = 0;
    tick();

    // Out-of-range write is dropped and flags the sticky error
    cfg_write(7'd73, 6'h3F, 1'b0);
    chk("bad_addr_err", cfg_err, 1'b1);
    chk("bad_addr_params", dp_params, exp_params);
    cfg_write(7'd0, 6'h1F, 1'b0);  exp_params[5:0] = 6'h1F;
    cfg_write(7'd37, 6'h2A, 1'b0); exp_params[37*PW +: PW] = 6'h2A;
    chk("err_sticky", cfg_err, 1'b1);
    cfg_write(7'd72, 6'h21, 1'b1); exp_params[72*PW +: PW] = 6'h21;
    chk("commit_state", state, 2'd1);
    chk("param0", dp_params[5:0], 6'h1F);
    chk("param72", dp_params[437:432], 6'h21);
    chk("params_all", dp_params, exp_params);
    chk("run_cfg_ready", cfg_ready, 1'b0);
    cfg_write(7'd5, 6'h15, 1'b0);
    chk("run_write_blocked", dp_params, exp_params);

    // 10 back-to-back samples, no backpressure
    extra_lat = 0; out_ready = 1; occ_max = 0; hs0 = hs_cnt;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i < 10);
      in_x = 24'(i) * 24'h010203;
      #1;
      if (i < 10) chk("t3_in_ready", in_ready, 1'b1);
      if (i == 3) chk("dp_x", dp_x, in_x);
      if (i == 10) chk("t3_occ10", occupancy, 5'd10);
      chk("t3_out_valid", out_valid, (i >= 24 && i <= 33));
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      tick();
    end
    in_valid = 0;
    chk("t3_occ_peak", occ_max, 10);
    chk("t3_handshakes", hs_cnt - hs0, 10);
    chk("t3_occ_end", occupancy, '0);

    // 5 samples with a 7-cycle output stall
    extra_lat = 7; hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_x = 24'h100000 + 24'(i);
      tick();
    end
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk("t4_first_out_wait", n, 19);
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("t4_stall_dp_enable", dp_enable, 1'b0);
      chk("t4_stall_in_ready", in_ready, 1'b0);
      chk("t4_stall_out_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1; in_valid = 0;
    n = 0;
    while (occupancy != '0 && n < 100) begin tick(); n++; end
    chk("t4_drained", occupancy, '0);
    chk("t4_handshakes", hs_cnt - hs0, 5);
    chk("t4_sb_empty", sb_q.size(), 0);

    // cfg_req with 3 samples in flight
    extra_lat = 0; hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; tick();
    end
    in_valid = 0; cfg_req = 1;
    #1;
    chk("t5_occ3", occupancy, 5'd3);
    tick();
    cfg_req = 0; in_valid = 1;
    #1;
    chk("t5_state_drain", state, 2'd2);
    chk("t5_in_ready", in_ready, 1'b0);
    n = 0;
    while (occupancy != '0 && n < 100) begin
      chk("t5_drain_hold", state, 2'd2);
      tick(); n++;
    end
    chk("t5_last_drain", state, 2'd2);
    tick();
    chk("t5_back_cfg", state, 2'd0);
    chk("t5_cfg_ready", cfg_ready, 1'b1);
    chk("t5_handshakes", hs_cnt - hs0, 3);
    in_valid = 0;

    // cfg_req ignored in CFG; cfg_req with nothing in flight
    cfg_req = 1; tick(); cfg_req = 0;
    chk("cfg_req_ignored", state, 2'd0);
    cfg_commit = 1; tick(); cfg_commit = 0;
    chk("t5b_run", state, 2'd1);
    cfg_req = 1; tick(); cfg_req = 0;
    chk("t5b_drain", state, 2'd2);
    tick();
    chk("t5b_cfg", state, 2'd0);

    // Reset mid-RUN with 12 in flight
    cfg_commit = 1; tick(); cfg_commit = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; tick();
    end
    in_valid = 0;
    #1;
    chk("t6_occ12", occupancy, 5'd12);
`ifdef GAN_CTRL_PERF_EN
    chk("perf_samples", perf_samples, 32'(hs_cnt));
    chk("perf_stalls", perf_stalls, 32'd7);
`endif
    #1;
    reset = 1;
    #1;
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_occupancy", occupancy, '0);
    chk("t6_params", dp_params, '0);
    chk("t6_state", state, 2'd0);
    chk("t6_cfg_err", cfg_err, 1'b0);
    chk("t6_cfg_ready", cfg_ready, 1'b1);
    chk("t6_dp_enable", dp_enable, 1'b0);
`ifdef GAN_CTRL_PERF_EN
    chk("t6_perf_samples", perf_samples, '0);
    chk("t6_perf_stalls", perf_stalls, '0);
`endif
    sb_q.delete();
    tick();
    reset = 0;
    tick();
    chk("t6_post_state", state, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gan_pipeline_ctrl.md
# gan_pipeline_ctrl

Controller for the 8-layer pipelined GAN datapath. It holds the datapath's 73 signed 6-bit weight/bias parameters, loaded through a serial config handshake. It gates the datapath's global `enable` for valid/ready flow control with output backpressure, and tracks in-flight samples so `out_valid` lines up with the datapath's f1..f4. It sits between the host/stream logic and the datapath instance, which it feeds via `dp_enable`, `dp_x` and `dp_params`.

## Interface
Parameters:
- `PIPE_LAT`, default 24: datapath latency in enabled cycles, from x sampled to f valid.
- `NUM_PARAMS`, default 73: number of weight/bias registers.
- `PARAM_W`, default 6: parameter width.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted when this and `cfg_valid` are both high.
- `cfg_addr` in 7: parameter index.
- `cfg_data` in 6: parameter value.
- `cfg_commit` in 1: single-cycle pulse, leaves CFG.
- `cfg_req` in 1: single-cycle pulse, requests return to CFG.
- `cfg_err` out 1: sticky, set by an out-of-range address.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: input sample accepted.
- `in_x` in 24: {x4,x3,x2,x1}.
- `out_valid` out 1: datapath f1..f4 hold a valid result.
- `out_ready` in 1: downstream accepts the result.
- `dp_enable` out 1: datapath enable.
- `dp_x` out 24: combinational copy of `in_x`.
- `dp_params` out 438: parameter index k occupies bits [6k+5:6k].
- `occupancy` out clog2(PIPE_LAT+1): valid samples in flight.
- `state` out 2: current FSM state.

## Operation
FSM states: CFG=0 (reset state), RUN=1, DRAIN=2.
- CFG:
  - `cfg_ready`=1, `in_ready`=0, `dp_enable`=0.
  - On `cfg_commit` the FSM moves to RUN.
  - `cfg_req` is ignored.
- RUN:
  - `cfg_ready`=0.
  - `in_ready` = !stall.
  - On `cfg_req` the FSM moves to DRAIN.
  - `cfg_commit` is ignored.
- DRAIN:
  - `in_ready`=0.
  - The pipeline keeps advancing.
  - When `occupancy`==0 the FSM moves to CFG.

Flow control:
- stall = `out_valid` & !`out_ready`.
- `dp_enable` = (state != CFG) & !stall.
- A pipeline stall freezes the whole datapath. There is no partial advance.

Valid tracking:
- Shift register `vld[PIPE_LAT-1:0]` shifts only when `dp_enable`=1.
- The bit shifted in is `in_valid` & `in_ready`.
- `out_valid` = `vld[PIPE_LAT-1]`.
- `occupancy` changes per enabled cycle: +1 for an accept, -1 for a bit shifted out, net 0 when both happen together.

Config writes:
- A write with `cfg_addr` < NUM_PARAMS updates the register on the handshake edge.
- A write with `cfg_addr` >= NUM_PARAMS is accepted and dropped, and sets `cfg_err`.
- `cfg_err` clears only on reset.

Parameter order follows the datapath port list:
- L1 w11..w44, b1..b4: index 0–19.
- L2: 20–29.
- L3: 30–32.
- L4: 33–34.
- L5: 35–36.
- L6: 37–40.
- L7: 41–52.
- L8: 53–72.

## Timing
Reset values:
- state=CFG.
- All params=0, `vld`=0, `occupancy`=0.
- `cfg_err`=0, `out_valid`=0, `dp_enable`=0, `in_ready`=0.
- `cfg_ready`=1.
- Reset asserted mid-RUN or mid-DRAIN discards in-flight samples immediately and returns to CFG.

Latency and throughput:
- A sample accepted at edge t gives `out_valid`=1 after PIPE_LAT further enabled cycles.
- Each stall cycle adds one cycle of latency.
- Throughput is 1 sample per cycle when there is no stall.

Combinational paths:
- `dp_enable` and `in_ready` depend combinationally on `out_ready`.
- `dp_x` is a wire copy of `in_x`.

Simultaneous events:
- `cfg_valid` and `cfg_commit` in the same cycle: the write lands and the state is RUN next cycle, using the new value.
- `cfg_req` while stalled: the FSM enters DRAIN. DRAIN exits only after the last result's output handshake.
- `cfg_req` with `occupancy`=0: the FSM spends one DRAIN cycle, then CFG.

Parameters are stable during RUN and DRAIN because writes are blocked there.

## Configuration
Macro `GAN_CTRL_PERF_EN`.
- Defined: adds two outputs, 32-bit each, reset to 0, saturating at all-ones.
  - `perf_samples` counts output handshakes.
  - `perf_stalls` counts cycles with stall=1.
- Undefined: neither port nor any counter logic exists.

## Structure
- Package `gan_ctrl_pkg` holds:
  - NUM_PARAMS and PARAM_W.
  - The state encoding constants CFG/RUN/DRAIN.
  - Per-layer base index constants: L1=0, L2=20, L3=30, L4=33, L5=35, L6=37, L7=41, L8=53.
- Sub-module `gan_valid_tracker` holds the `vld` shift register and the `occupancy` counter.
  - Inputs: shift enable, valid in.
  - Outputs: valid out, occupancy.

## Test plan
- Reset, then write index 0=6'h1F, 72=6'h21 and commit → `dp_params[5:0]`=1F, `dp_params[437:432]`=21; `state`=RUN next cycle.
- Write `cfg_addr`=73 → `cfg_err`=1 and `dp_params` unchanged; a second valid write leaves `cfg_err`=1.
- RUN with `out_ready`=1, 10 back-to-back samples → `out_valid` high exactly cycles 24–33 after the first accept; `occupancy` peaks at 10.
- Fill 5 samples, hold `out_ready`=0 for 7 cycles once `out_valid`=1 → `dp_enable`=0 and `in_ready`=0 for those 7 cycles, no result lost, 5 handshakes total.
- `cfg_req` with 3 in flight → `in_ready`=0 at once; state returns to CFG the cycle after `occupancy` reaches 0; `cfg_ready`=1.
- Reset asserted mid-RUN with `occupancy`=12 → `out_valid`, `occupancy` and params read 0 and `state`=CFG at once; with `GAN_CTRL_PERF_EN`, both counters read 0.
